// File: rtl/wash_program_controller.sv
`default_nettype none
// ============================================================================
// wash_program_controller: wash/rinse/spin program sequencer with fill and
// drain timeouts, pause and fault recovery.  Rev 1.0
// ============================================================================
module wash_program_controller #(
  parameter int AGITATE_CYCLES = 100,
  parameter int SPIN_CYCLES    = 60,
  parameter int FILL_TIMEOUT   = 200,
  parameter int DRAIN_TIMEOUT  = 200
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       pause,
  input  logic       full,
  input  logic       empty,
  input  logic [1:0] rinse_count,
  output logic       valve,
  output logic       drain,
  output logic       shake_mode,
  output logic       turn_mode,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FILL    = 3'd1,
    AGITATE = 3'd2,
    DRAIN   = 3'd3,
    SPIN    = 3'd4,
    DONE    = 3'd5,
    FAULT   = 3'd6
  } state_t;

  localparam logic [15:0] AGITATE_LAST = 16'(AGITATE_CYCLES - 1);
  localparam logic [15:0] SPIN_LAST    = 16'(SPIN_CYCLES - 1);
  localparam logic [15:0] FILL_LAST    = 16'(FILL_TIMEOUT - 1);
  localparam logic [15:0] DRAIN_LAST   = 16'(DRAIN_TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] timer;
  logic [1:0]  rinse_left;
  logic        active;
  logic        hold;

  always_comb begin
    state_nxt = state;
    active    = (state == FILL) || (state == AGITATE) ||
                (state == DRAIN) || (state == SPIN);
    hold      = active && pause;
    // A paused phase evaluates neither sensors nor timeouts.
    if (!hold) begin
      case (state)
        IDLE:    if (start) state_nxt = FILL;
        FILL:    if (full) state_nxt = AGITATE;
                 else if (timer == FILL_LAST) state_nxt = FAULT;
        AGITATE: if (timer == AGITATE_LAST) state_nxt = DRAIN;
        DRAIN:   if (empty) state_nxt = (rinse_left != 2'd0) ? FILL : SPIN;
                 else if (timer == DRAIN_LAST) state_nxt = FAULT;
        SPIN:    if (timer == SPIN_LAST) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        FAULT:   if (start) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      timer      <= 16'd0;
      rinse_left <= 2'd0;
      valve      <= 1'b0;
      drain      <= 1'b0;
      shake_mode <= 1'b0;
      turn_mode  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
      phase      <= 3'd0;
    end else begin
      state <= state_nxt;
      phase <= state_nxt;

      if (state_nxt != state)
        timer <= 16'd0;
      else if (active && !pause && timer != 16'hFFFF)
        timer <= timer + 16'd1;

      case (state)
        IDLE:    if (start) rinse_left <= rinse_count;
        DRAIN:   if (!pause && empty && rinse_left != 2'd0)
                   rinse_left <= rinse_left - 2'd1;
        FAULT:   if (start) rinse_left <= 2'd0;
        default: ;
      endcase

      // Outputs follow the next state so they change on the same edge.
      valve      <= (state_nxt == FILL) && !hold;
      shake_mode <= (state_nxt == AGITATE) && !hold;
      turn_mode  <= (state_nxt == SPIN) && !hold;
      drain      <= (((state_nxt == DRAIN) || (state_nxt == SPIN)) && !hold) ||
                    (state_nxt == FAULT);
      busy       <= (state_nxt == FILL) || (state_nxt == AGITATE) ||
                    (state_nxt == DRAIN) || (state_nxt == SPIN);
      done       <= (state_nxt == DONE);
      fault      <= (state_nxt == FAULT);
    end
  end

endmodule
`default_nettype wire
